column_render_sched: RTL

Frame-level scheduler that sequences the raycaster column by column and fills the off-screen half of a double-buffered 640x480 colour frame buffer. On each frame strobe it latches the player pose and issues one cast request per column. For each column it expands the returned wall span into V_RES pixel writes: ceiling, then wall, then floor. It swaps the display/draw buffers only at a frame strobe after a complete render, so the VGA scan-out never reads a half-drawn frame.

---
 rtl/column_render_sched.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/column_render_sched.sv
// Frame scheduler: casts one ray per column and expands each wall span into V_RES frame-buffer writes.
// Latency: best case 3 cycles per column plus cast time plus V_RES fill cycles.
// Backpressure: i_fb_ready low stalls FILL with o_fb_x/y/data held; the cast handshake is bounded by RAY_TIMEOUT.
//
// Ports:
//   CLK, RST_BTN         clock and asynchronous active-low reset
//   i_en, i_frame_stb    render enable (sampled only at frame start) and vsync strobe
//   i_pos_x/y, i_angle   player pose, latched once per frame onto o_ray_x/y/ang
//   o_ray_start/col      one-cycle cast request and column being cast
//   i_ray_done, i_wall_* cast result: inclusive wall rows and wall colour
//   o_fb_we/x/y/data     pixel write, accepted when i_fb_ready is high
//   o_fb_sel             buffer being drawn; scan-out reads the other one
//   o_busy, o_frame_done, o_timeout_err, o_overrun_cnt  status
module column_render_sched #(
  parameter int          H_RES       = 640,
  parameter int          V_RES       = 480,
  parameter logic [5:0]  CEIL_COLOR  = 6'b000001,
  parameter logic [5:0]  FLOOR_COLOR = 6'b010100,
  parameter int          RAY_TIMEOUT = 4096
) (
  input  logic       CLK,
  input  logic       RST_BTN,
  input  logic       i_en,
  input  logic       i_frame_stb,
  input  logic [5:0] i_pos_x,
  input  logic [5:0] i_pos_y,
  input  logic [5:0] i_angle,
  output logic       o_ray_start,
  output logic [9:0] o_ray_col,
  output logic [5:0] o_ray_x,
  output logic [5:0] o_ray_y,
  output logic [5:0] o_ray_ang,
  input  logic       i_ray_done,
  input  logic [8:0] i_wall_top,
  input  logic [8:0] i_wall_bot,
  input  logic [5:0] i_wall_color,
  output logic       o_fb_we,
  input  logic       i_fb_ready,
  output logic [9:0] o_fb_x,
  output logic [8:0] o_fb_y,
  output logic [5:0] o_fb_data,
  output logic       o_fb_sel,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_timeout_err,
  output logic [7:0] o_overrun_cnt
);

  localparam logic [9:0] LAST_COL = 10'(H_RES - 1);
  localparam logic [8:0] LAST_ROW = 9'(V_RES - 1);
  localparam logic [8:0] HORIZON  = 9'(V_RES / 2);
  localparam int         TW       = $clog2(RAY_TIMEOUT) + 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'(RAY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_CAST,
    S_WAIT,
    S_FILL,
    S_NEXT,
    S_DONE
  } state_t;

  state_t        state;
  logic [9:0]    col;
  logic [8:0]    top_q;
  logic [8:0]    bot_q;
  logic [5:0]    wcol_q;
  logic [TW-1:0] wait_cnt;

  // The cast column is the column counter itself, so it cannot move between
  // start and done.
  assign o_ray_col = col;

  // Colour of row y for a span [top, bot]. bot past the screen is clamped.
  // When top > bot the span is empty; rows that are simultaneously above top
  // and below bot are split at the horizon so an empty column still shows a
  // ceiling over a floor (an abandoned cast, top=511/bot=0, gives a half/half
  // column).
  function automatic logic [5:0] pix_color(input logic [8:0] y,
                                           input logic [8:0] top,
                                           input logic [8:0] bot,
                                           input logic [5:0] wc);
    logic [8:0] b;
    logic [5:0] c;
    b = (bot > LAST_ROW) ? LAST_ROW : bot;
    if (top <= b) begin
      if (y < top)       c = CEIL_COLOR;
      else if (y <= b)   c = wc;
      else               c = FLOOR_COLOR;
    end else begin
      if ((y < top) && ((y <= b) || (y < HORIZON))) c = CEIL_COLOR;
      else                                          c = FLOOR_COLOR;
    end
    return c;
  endfunction

  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      state         <= S_IDLE;
      col           <= '0;
      top_q         <= '0;
      bot_q         <= '0;
      wcol_q        <= '0;
      wait_cnt      <= '0;
      o_ray_start   <= 1'b0;
      o_ray_x       <= '0;
      o_ray_y       <= '0;
      o_ray_ang     <= '0;
      o_fb_we       <= 1'b0;
      o_fb_x        <= '0;
      o_fb_y        <= '0;
      o_fb_data     <= '0;
      o_fb_sel      <= 1'b0;
      o_busy        <= 1'b0;
      o_frame_done  <= 1'b0;
      o_timeout_err <= 1'b0;
      o_overrun_cnt <= '0;
    end else begin
      // Single-cycle pulses default low.
      o_ray_start  <= 1'b0;
      o_frame_done <= 1'b0;

      // A strobe while a frame is in flight cannot start a new one; count it.
      if (i_frame_stb && (state != S_IDLE) && (state != S_DONE) &&
          (o_overrun_cnt != 8'hFF)) begin
        o_overrun_cnt <= o_overrun_cnt + 8'd1;
      end

      case (state)
        S_IDLE: begin
          if (i_frame_stb && i_en) begin
            state  <= S_LATCH;
            o_busy <= 1'b1;
          end
        end

        S_LATCH: begin
          o_ray_x     <= i_pos_x;
          o_ray_y     <= i_pos_y;
          o_ray_ang   <= i_angle;
          col         <= '0;
          o_ray_start <= 1'b1;
          state       <= S_CAST;
        end

        // o_ray_start is high for exactly this cycle; a done pulse seen here
        // belongs to no request and is dropped.
        S_CAST: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          if (i_ray_done) begin
            top_q     <= i_wall_top;
            bot_q     <= i_wall_bot;
            wcol_q    <= i_wall_color;
            o_fb_x    <= col;
            o_fb_y    <= '0;
            o_fb_data <= pix_color(9'd0, i_wall_top, i_wall_bot, i_wall_color);
            o_fb_we   <= 1'b1;
            state     <= S_FILL;
          end else if (wait_cnt == WAIT_LAST) begin
            // Abandon the cast and draw an empty column.
            o_timeout_err <= 1'b1;
            top_q         <= 9'h1FF;
            bot_q         <= 9'h000;
            wcol_q        <= '0;
            o_fb_x        <= col;
            o_fb_y        <= '0;
            o_fb_data     <= pix_color(9'd0, 9'h1FF, 9'h000, 6'd0);
            o_fb_we       <= 1'b1;
            state         <= S_FILL;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        // Address and data only move on an accepted write.
        S_FILL: begin
          if (i_fb_ready) begin
            if (o_fb_y == LAST_ROW) begin
              o_fb_we <= 1'b0;
              state   <= S_NEXT;
              if (col == LAST_COL) o_frame_done <= 1'b1;
            end else begin
              o_fb_y    <= o_fb_y + 9'd1;
              o_fb_data <= pix_color(o_fb_y + 9'd1, top_q, bot_q, wcol_q);
            end
          end
        end

        S_NEXT: begin
          if (col == LAST_COL) begin
            col    <= '0;
            o_busy <= 1'b0;
            state  <= S_DONE;
          end else begin
            col         <= col + 10'd1;
            o_ray_start <= 1'b1;
            state       <= S_CAST;
          end
        end

        // The finished frame becomes visible only at a vsync strobe.
        S_DONE: begin
          if (i_frame_stb) begin
            o_fb_sel <= ~o_fb_sel;
            if (i_en) begin
              state  <= S_LATCH;
              o_busy <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
